// File: rtl/cam_sdram_wr_pkg.sv
// Shared types and default geometry for the camera-to-SDRAM write path.
package cam_sdram_wr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam int BURST_LEN_DEF   = 8;
    localparam int FIFO_DEPTH_DEF  = 16;
    localparam int FRAME_WORDS_DEF = 307200;
    localparam int ADDR_W          = 24;
    localparam int PIX_W           = 16;

    // Base address of the following burst, wrapping at the end of the frame.
    function automatic logic [ADDR_W-1:0] next_burst_addr(
        input logic [ADDR_W-1:0] addr,
        input int unsigned       burst_len,
        input int unsigned       frame_words
    );
        if (addr >= ADDR_W'(frame_words - burst_len)) begin
            return '0;
        end else begin
            return addr + ADDR_W'(burst_len);
        end
    endfunction

endpackage

// File: rtl/cam_sdram_wr_sync_fifo.sv
// Single-clock FIFO with synchronous clear; head word is visible on dout_o.
module sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d, wa_s;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + AW'(1);
        end
    endfunction

    // Pointer and occupancy next-state; a clear restarts at slot 0 but keeps a same-cycle push.
    always_comb begin
        do_pop_s  = pop_i && !empty_o;
        do_push_s = push_i && (clr_i || !full_o || do_pop_s);
        wa_s      = clr_i ? '0 : wr_q;
        if (clr_i) begin
            rd_d  = '0;
            wr_d  = do_push_s ? AW'(1) : '0;
            cnt_d = do_push_s ? LW'(1) : '0;
        end else begin
            rd_d  = do_pop_s ? ptr_inc(rd_q) : rd_q;
            wr_d  = do_push_s ? ptr_inc(wr_q) : wr_q;
            cnt_d = cnt_q + LW'(do_push_s) - LW'(do_pop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wa_s] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;

endmodule

// File: rtl/cam_sdram_wr.sv
// Buffers camera pixels and writes them to SDRAM as fixed-length bursts.
module cam_sdram_wr
    import cam_sdram_wr_pkg::*;
#(
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pix_valid,
    input  logic [15:0]                    pix_data,
    input  logic                           frame_start,
    output logic                           wr_sdram_req,
    input  logic                           wr_sdram_ack,
    output logic [23:0]                    wr_sdram_add,
    output logic [15:0]                    wr_sdram_data,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           ovf_err,
    output logic                           busy
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(BURST_LEN) + 1;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   add_q, add_d;
    logic [PIX_W-1:0]    data_q, data_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                pend_q, pend_d;
    logic                push_s, pop_s, clr_s, full_s, empty_s;
    logic [PIX_W-1:0]    head_s;
    logic [LW-1:0]       level_s;

    sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr_s),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (pix_data),
        .dout_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level_s)
    );

    // Burst FSM, address counter and frame-start handling.
    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        add_d   = add_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q | frame_start;
        pop_s   = 1'b0;
        clr_s   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pend_q) begin
                    clr_s  = 1'b1;
                    add_d  = '0;
                    pend_d = frame_start;
                end else if ((level_s >= LW'(BURST_LEN)) && !frame_start) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (wr_sdram_ack) begin
                    state_d = BURST;
                end else begin
                    req_d = 1'b1;
                end
            end
            BURST: begin
                pop_s  = !empty_s;
                data_d = head_s;
                if (cnt_q == CW'(BURST_LEN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    add_d   = next_burst_addr(add_q, BURST_LEN, FRAME_WORDS);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A full FIFO still accepts a pixel when a word leaves in the same cycle.
        push_s = pix_valid && (clr_s || !full_s || pop_s);
        ovf_d  = clr_s ? 1'b0 : (ovf_q | (pix_valid & ~push_s));
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            add_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            add_q   <= add_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    assign wr_sdram_req  = req_q;
    assign wr_sdram_add  = add_q;
    assign wr_sdram_data = (state_q == BURST) ? head_s : data_q;
    assign fifo_level    = level_s;
    assign ovf_err       = ovf_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cam_sdram_wr.sv
// Testbench for cam_sdram_wr: table-driven bursts, directed corner cases, random run vs queue model.
module tb_cam_sdram_wr;

    localparam int BL = 8;
    localparam int FD = 16;
    localparam int FW = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = 16'h0000;
    logic        frame_start = 1'b0;
    logic        wr_sdram_ack = 1'b0;
    logic        wr_sdram_req;
    logic [23:0] wr_sdram_add;
    logic [15:0] wr_sdram_data;
    logic [4:0]  fifo_level;
    logic        ovf_err;
    logic        busy;

    int total = 0;
    int bad = 0;

    cam_sdram_wr #(
        .BURST_LEN   (BL),
        .FIFO_DEPTH  (FD),
        .FRAME_WORDS (FW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .frame_start   (frame_start),
        .wr_sdram_req  (wr_sdram_req),
        .wr_sdram_ack  (wr_sdram_ack),
        .wr_sdram_add  (wr_sdram_add),
        .wr_sdram_data (wr_sdram_data),
        .fifo_level    (fifo_level),
        .ovf_err       (ovf_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [15:0] base;
        int          dly;
        logic [23:0] add0;
        logic [23:0] add1;
        int          lvl;
        logic [15:0] d0;
        logic [15:0] d7;
    } vec_t;

    vec_t vecs[4];

    // reference model state
    logic [15:0] mq[$];
    int          m_add, m_phase, m_cnt;
    bit          m_ovf, m_pend;
    logic [15:0] m_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_req(input string nm);
        int k;
        k = 0;
        while (!wr_sdram_req && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " req_timeout"}, 32'(wr_sdram_req), 1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " req"},   32'(wr_sdram_req), 0);
        chk({nm, " add"},   32'(wr_sdram_add), 0);
        chk({nm, " data"},  32'(wr_sdram_data), 0);
        chk({nm, " level"}, 32'(fifo_level), 0);
        chk({nm, " ovf"},   32'(ovf_err), 0);
        chk({nm, " busy"},  32'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{8,  16'h0001, 3, 24'd0,  24'd8,  0, 16'h0001, 16'h0008};
        vecs[1] = '{10, 16'h0100, 0, 24'd8,  24'd16, 2, 16'h0100, 16'h0107};
        vecs[2] = '{6,  16'h0200, 1, 24'd16, 24'd24, 0, 16'h0108, 16'h0205};
        vecs[3] = '{8,  16'hFFF8, 2, 24'd24, 24'd32, 0, 16'hFFF8, 16'hFFFF};

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // table of single bursts
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                pix_valid = 1'b1;
                pix_data  = vecs[v].base + 16'(i);
                @(negedge clk);
            end
            pix_valid = 1'b0;
            wait_req($sformatf("vec%0d", v));
            for (int d = 0; d < vecs[v].dly; d++) begin
                chk($sformatf("vec%0d req_hold", v), 32'(wr_sdram_req), 1);
                chk($sformatf("vec%0d add_hold", v), 32'(wr_sdram_add), 32'(vecs[v].add0));
                @(negedge clk);
            end
            chk($sformatf("vec%0d add_at_ack", v), 32'(wr_sdram_add), 32'(vecs[v].add0));
            wr_sdram_ack = 1'b1;
            @(negedge clk);
            wr_sdram_ack = 1'b0;
            for (int w = 0; w < BL; w++) begin
                chk($sformatf("vec%0d burst_req", v), 32'(wr_sdram_req), 0);
                chk($sformatf("vec%0d burst_busy", v), 32'(busy), 1);
                if (w == 0) chk($sformatf("vec%0d d0", v), 32'(wr_sdram_data), 32'(vecs[v].d0));
                if (w == BL - 1) chk($sformatf("vec%0d d7", v), 32'(wr_sdram_data), 32'(vecs[v].d7));
                @(negedge clk);
            end
            chk($sformatf("vec%0d add_next", v), 32'(wr_sdram_add), 32'(vecs[v].add1));
            chk($sformatf("vec%0d level", v), 32'(fifo_level), 32'(vecs[v].lvl));
            chk($sformatf("vec%0d busy_end", v), 32'(busy), 0);
        end

        // overflow with ack withheld, then frame_start during the burst
        for (int i = 0; i < 30; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'h0300 + 16'(i);
            @(negedge clk);
        end
        chk("ovf level", 32'(fifo_level), 16);
        chk("ovf flag", 32'(ovf_err), 1);
        chk("ovf req", 32'(wr_sdram_req), 1);
        chk("ovf add", 32'(wr_sdram_add), 32);
        wr_sdram_ack = 1'b1;
        pix_valid    = 1'b0;
        @(negedge clk);
        wr_sdram_ack = 1'b0;
        for (int w = 0; w < BL; w++) begin
            chk("fs burst data", 32'(wr_sdram_data), 32'(16'h0300 + 16'(w)));
            frame_start = (w == 2);
            @(negedge clk);
        end
        frame_start = 1'b0;
        chk("fs idle busy", 32'(busy), 0);
        chk("fs ovf sticky", 32'(ovf_err), 1);
        chk("fs add pre", 32'(wr_sdram_add), 40);
        chk("fs level pre", 32'(fifo_level), 8);
        pix_valid = 1'b1;
        pix_data  = 16'hABCD;
        @(negedge clk);
        pix_valid = 1'b0;
        chk("fs level", 32'(fifo_level), 1);
        chk("fs add", 32'(wr_sdram_add), 0);
        chk("fs ovf", 32'(ovf_err), 0);
        chk("fs req", 32'(wr_sdram_req), 0);

        // reset in the middle of a burst
        for (int i = 0; i < 7; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'hB000 + 16'(i);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        wait_req("rstburst");
        chk("rstburst add", 32'(wr_sdram_add), 0);
        wr_sdram_ack = 1'b1;
        @(negedge clk);
        wr_sdram_ack = 1'b0;
        chk("rstburst word0", 32'(wr_sdram_data), 32'h0000ABCD);
        @(negedge clk);
        chk("rstburst word1", 32'(wr_sdram_data), 32'h0000B000);
        @(negedge clk);
        chk("rstburst word2", 32'(wr_sdram_data), 32'h0000B001);
        @(negedge clk);
        chk("rstburst word3", 32'(wr_sdram_data), 32'h0000B002);
        #1 rst = 1'b1;
        #1 chk_reset_vals("midburst_rst");
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            chk("post_rst no_req", 32'(wr_sdram_req), 0);
            pix_valid = 1'b1;
            pix_data  = 16'hC000 + 16'(i);
            @(negedge clk);
        end
        chk("post_rst level7", 32'(fifo_level), 7);
        chk("post_rst req7", 32'(wr_sdram_req), 0);
        pix_data = 16'hC007;
        @(negedge clk);
        pix_valid = 1'b0;
        chk("post_rst level8", 32'(fifo_level), 8);
        chk("post_rst req8", 32'(wr_sdram_req), 0);
        @(negedge clk);
        chk("post_rst req_rise", 32'(wr_sdram_req), 1);

        // random traffic against the queue model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_add = 0; m_phase = 0; m_cnt = 0; m_ovf = 1'b0; m_pend = 1'b0; m_last = 16'h0000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int          sz;
            bit          pv, ack, fs, popping, pend_old;
            logic [15:0] pd, exp_data;
            exp_data = (m_phase == 2 && mq.size() > 0) ? mq[0] : m_last;
            chk("rnd req",   32'(wr_sdram_req), 32'(m_phase == 1));
            chk("rnd busy",  32'(busy), 32'(m_phase != 0));
            chk("rnd level", 32'(fifo_level), 32'(mq.size()));
            chk("rnd ovf",   32'(ovf_err), 32'(m_ovf));
            chk("rnd add",   32'(wr_sdram_add), 32'(m_add));
            chk("rnd data",  32'(wr_sdram_data), 32'(exp_data));

            pv  = ($urandom_range(0, 9) < 8);
            pd  = 16'($urandom);
            ack = ($urandom_range(0, 3) == 0);
            fs  = ($urandom_range(0, 199) == 0);
            pix_valid    = pv;
            pix_data     = pd;
            wr_sdram_ack = ack;
            frame_start  = fs;

            sz       = mq.size();
            popping  = (m_phase == 2);
            pend_old = m_pend;
            if (m_phase == 0 && m_pend) begin
                mq.delete();
                m_add  = 0;
                m_ovf  = 1'b0;
                m_pend = fs;
                if (pv) mq.push_back(pd);
            end else begin
                m_pend = m_pend | fs;
                if (popping) m_last = mq.pop_front();
                if (pv) begin
                    if (sz < FD || popping) mq.push_back(pd);
                    else m_ovf = 1'b1;
                end
                if (m_phase == 0) begin
                    if (!pend_old && !fs && sz >= BL) m_phase = 1;
                end else if (m_phase == 1) begin
                    if (ack) begin
                        m_phase = 2;
                        m_cnt   = 0;
                    end
                end else begin
                    m_cnt++;
                    if (m_cnt == BL) begin
                        m_phase = 0;
                        m_add   = (m_add + BL) % FW;
                    end
                end
            end
            @(negedge clk);
        end
        pix_valid = 1'b0;
        wr_sdram_ack = 1'b0;
        frame_start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_sdram_wr.md
CAM_SDRAM_WR -- requirements
Module: cam_sdram_wr

Interface
REQ-001 Parameter BURST_LEN, default 8, words per SDRAM write burst.
REQ-002 Parameter FIFO_DEPTH, default 16, pixel FIFO depth in words; must be ≥ 2*BURST_LEN.
REQ-003 Parameter FRAME_WORDS, default 307200, words per frame; must be a multiple of BURST_LEN.
REQ-004 Clock and reset ports: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock, same clock as the SDRAM controller.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 pix_valid  in  1  camera pixel strobe.
REQ-008 pix_data  in  16  RGB565 pixel.
REQ-009 frame_start  in  1  single-cycle start-of-frame pulse.
REQ-010 wr_sdram_req  out  1  write-burst request to the SDRAM controller.
REQ-011 wr_sdram_ack  in  1  single-cycle grant from the SDRAM controller.
REQ-012 wr_sdram_add  out  24  burst base word address.
REQ-013 wr_sdram_data  out  16  write data word.
REQ-014 fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 ovf_err  out  1  sticky flag: a pixel was dropped.
REQ-016 busy  out  1  high in states REQ and BURST.

Function
REQ-017 Pixel FIFO: a write occurs when pix_valid=1 and the FIFO is not full. A simultaneous push and pop when full is allowed; the pushed pixel is accepted.
REQ-018 When pix_valid=1, the FIFO is full and no pop occurs, the pixel is dropped and ovf_err is set; ovf_err stays set until a frame_start is applied.
REQ-019 States: IDLE, REQ, BURST.
REQ-020 IDLE -> REQ when fifo_level ≥ BURST_LEN and no frame_start is pending; wr_sdram_req is registered and rises in the first REQ cycle.
REQ-021 In REQ, wr_sdram_req holds at 1 and wr_sdram_add holds stable until the cycle T in which wr_sdram_ack=1; the state then changes to BURST.
REQ-022 In BURST, wr_sdram_req=0. wr_sdram_data shows the FIFO head in cycles T+1 .. T+BURST_LEN, and one word is popped in each of those cycles.
REQ-023 After the last word, wr_sdram_add increments by BURST_LEN and the state returns to IDLE at T+BURST_LEN+1.
REQ-024 wr_sdram_add wraps from FRAME_WORDS-BURST_LEN to 0.
REQ-025 When FIFO data is not being driven, wr_sdram_data holds its last value.
REQ-026 A frame_start pulse sets a pending flag. The flag is applied only in IDLE: the FIFO is cleared, wr_sdram_add is set to 0, ovf_err is cleared, and the flag is cleared.
REQ-027 A frame_start during REQ or BURST does not abort the burst; it is applied on the first IDLE cycle after the burst.
REQ-028 A pix_valid in the same cycle that frame_start is applied is stored as word 0 of the new frame.
REQ-029 wr_sdram_ack is ignored in IDLE and BURST.
REQ-030 A partial burst (fifo_level < BURST_LEN) is never requested; residual words are discarded at the next applied frame_start.

Reset
REQ-031 On rst=1, immediately and asynchronously, including mid-burst: state=IDLE, wr_sdram_req=0, wr_sdram_add=0, wr_sdram_data=0, FIFO empty, fifo_level=0, ovf_err=0, busy=0, pending flag=0.
REQ-032 After rst deasserts, the first possible wr_sdram_req is no earlier than the cycle after fifo_level reaches BURST_LEN.

Structure
REQ-033 A shared package holds the state enumeration (IDLE/REQ/BURST) and the default constants for BURST_LEN, FIFO_DEPTH and FRAME_WORDS.
REQ-034 The FIFO is one sub-module, sync_fifo: parameterised width and depth, push, pop, clear, full, empty and level outputs.
REQ-035 The FSM and address counter are implemented in cam_sdram_wr itself.

Verification
REQ-036 Push 8 pixels 0x0001..0x0008, ack 3 cycles after req rises -> req holds 3 cycles with add=0x000000; data 0x0001..0x0008 on T+1..T+8; then add=0x000008 and fifo_level=0.
REQ-037 Continuous pix_valid, ack never asserted -> fifo_level saturates at 16, ovf_err=1, req stays high and add stays stable.
REQ-038 Stream a full frame of 307200 pixels -> the last burst has add=0x04AFF8, then add wraps to 0x000000.
REQ-039 frame_start in cycle T+3 of a burst -> all 8 words are still transferred; in the next IDLE cycle, fifo_level=0, add=0 and ovf_err=0.
REQ-040 rst pulse at cycle T+4 of a burst -> all outputs are at reset values in the same cycle; after release, no req until 8 new pixels are pushed.
